// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_digit_t : one 4-bit BCD digit
//   bcd_state_t : controller states IDLE -> SHIFT -> DONE
//   BCD_MAX     : largest value representable in four BCD digits
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [13:0] BCD_MAX = 14'd9999;

endpackage

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble correction cell. A digit of 5 or more is bumped by 3 so
// that the following left shift carries correctly into the next decade.
// Ports:
//   d : input work digit
//   q : corrected digit (d >= 5 ? d + 3 : d)
// ---------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    // Inputs never exceed 9, so the sum tops out at 12 and cannot wrap.
    assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bcd_seq_converter.sv
// ---------------------------------------------------------------------------
// bcd_seq_converter
// Multi-cycle binary-to-BCD converter: one double-dabble iteration per clock,
// with valid/ready handshakes on the input and output sides. Only one
// conversion is in flight at a time.
// Parameters:
//   IN_W     : binary input width, 1..14
//   SATURATE : 1 = values above 9999 read as 9999, 0 = value mod 10000
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   in_valid, in_ready, in_bin: input handshake and binary value
//   out_valid, out_ready      : output handshake
//   thousands..ones           : registered BCD result digits
//   overflow                  : input exceeded 9999, valid with out_valid
// ---------------------------------------------------------------------------
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter bit SATURATE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      thousands,
    output logic [3:0]      hundreds,
    output logic [3:0]      tens,
    output logic [3:0]      ones,
    output logic            overflow
);

    bcd_state_t      state;
    logic [3:0]      cnt;
    logic [IN_W-1:0] shreg;

    // Work digits; the ten-thousands digit only ever holds 0 or 1.
    bcd_digit_t w_ones;
    bcd_digit_t w_tens;
    bcd_digit_t w_hund;
    bcd_digit_t w_thou;
    logic [2:0] w_tth;

    // Corrected digits (after add-3) and the shifted next values.
    bcd_digit_t a_ones;
    bcd_digit_t a_tens;
    bcd_digit_t a_hund;
    bcd_digit_t a_thou;
    bcd_digit_t a_tth;
    bcd_digit_t tth_in;

    bcd_digit_t n_ones;
    bcd_digit_t n_tens;
    bcd_digit_t n_hund;
    bcd_digit_t n_thou;
    logic [2:0] n_tth;
    logic       n_ovf;
    logic       n_sat;

    assign tth_in = {1'b0, w_tth};

    bcd_add3 u_add3_ones (.d(w_ones), .q(a_ones));
    bcd_add3 u_add3_tens (.d(w_tens), .q(a_tens));
    bcd_add3 u_add3_hund (.d(w_hund), .q(a_hund));
    bcd_add3 u_add3_thou (.d(w_thou), .q(a_thou));
    bcd_add3 u_add3_tth  (.d(tth_in), .q(a_tth));

    // One double-dabble step: correct every digit, then shift the whole
    // chain left by one with the binary MSB entering the ones digit and each
    // digit's bit 3 rippling into the next decade. The final-step values are
    // also what the output registers capture, so the result is available the
    // cycle the last shift completes. Any bit that would leave the
    // ten-thousands digit is folded into the overflow flag.
    always_comb begin
        n_ones = {a_ones[2:0], shreg[IN_W-1]};
        n_tens = {a_tens[2:0], a_ones[3]};
        n_hund = {a_hund[2:0], a_tens[3]};
        n_thou = {a_thou[2:0], a_hund[3]};
        n_tth  = {a_tth[1:0],  a_thou[3]};
        n_ovf  = (n_tth != 3'd0) || (a_tth[3:2] != 2'b00);
        n_sat  = SATURATE && n_ovf;
    end

    // Controller, shift register, work digits and output registers.
    // IDLE accepts a value, SHIFT runs IN_W iterations counting cnt down to
    // zero, and the last SHIFT cycle loads the outputs as it enters DONE.
    // DONE holds everything until the consumer takes the result. Reset wins
    // over every handshake and aborts any conversion in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            shreg     <= '0;
            w_ones    <= 4'd0;
            w_tens    <= 4'd0;
            w_hund    <= 4'd0;
            w_thou    <= 4'd0;
            w_tth     <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            thousands <= 4'd0;
            hundreds  <= 4'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_bin;
                        w_ones   <= 4'd0;
                        w_tens   <= 4'd0;
                        w_hund   <= 4'd0;
                        w_thou   <= 4'd0;
                        w_tth    <= 3'd0;
                        cnt      <= 4'(IN_W - 1);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg  <= shreg << 1;
                    w_ones <= n_ones;
                    w_tens <= n_tens;
                    w_hund <= n_hund;
                    w_thou <= n_thou;
                    w_tth  <= n_tth;
                    if (cnt == 4'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        overflow  <= n_ovf;
                        thousands <= n_sat ? 4'd9 : n_thou;
                        hundreds  <= n_sat ? 4'd9 : n_hund;
                        tens      <= n_sat ? 4'd9 : n_tens;
                        ones      <= n_sat ? 4'd9 : n_ones;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_seq_converter
// Directed bench for bcd_seq_converter. Two instances share every input:
// dut saturates above 9999, dut_wrap wraps modulo 10000. Inputs are driven
// and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_seq_converter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [13:0] in_bin;
    logic        out_ready;

    logic        in_ready,  w_in_ready;
    logic        out_valid, w_out_valid;
    logic [3:0]  thousands, hundreds, tens, ones;
    logic [3:0]  w_thousands, w_hundreds, w_tens, w_ones;
    logic        overflow, w_overflow;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int acc_cyc    = 0;
    int prev_acc   = 0;

    bcd_seq_converter #(.IN_W(14), .SATURATE(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .overflow  (overflow)
    );

    bcd_seq_converter #(.IN_W(14), .SATURATE(1'b0)) dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_bin    (in_bin),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .thousands (w_thousands),
        .hundreds  (w_hundreds),
        .tens      (w_tens),
        .ones      (w_ones),
        .overflow  (w_overflow)
    );

    // Free-running clock and a posedge counter used to time accepts/results.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison point: counts the vector and reports any miscompare.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Present a value and wait (bounded) for it to be accepted. Returns on
    // the falling edge after the accept edge with acc_cyc recorded. With
    // keep set, in_valid stays high afterwards.
    task automatic send(input logic [13:0] value, input bit keep, input string tag);
        int waited = 0;
        in_bin   = value;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid. Counting the accept edge itself, the
    // result shows on the 15th clock, i.e. 14 edges after the accept edge.
    task automatic wait_result(input string tag);
        int waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(cyc - acc_cyc), 32'd14);
    endtask

    // Compare both instances' digits (packed as 4 hex nibbles) and flags.
    task automatic check_result(input string tag, input logic [15:0] sat_exp,
                                input logic [15:0] wrap_exp, input logic ov_exp);
        check({tag, " digits"}, 32'({thousands, hundreds, tens, ones}), 32'(sat_exp));
        check({tag, " overflow"}, 32'(overflow), 32'(ov_exp));
        check({tag, " wrap digits"}, 32'({w_thousands, w_hundreds, w_tens, w_ones}), 32'(wrap_exp));
        check({tag, " wrap overflow"}, 32'(w_overflow), 32'(ov_exp));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bin    = 14'd0;
        out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check_result("reset", 16'h0000, 16'h0000, 1'b0);

        // T1: 1234, consumer always ready
        $display("[TB] T1 convert 1234");
        send(14'd1234, 1'b0, "t1");
        check("t1 busy in_ready", 32'(in_ready), 32'd0);
        wait_result("t1");
        check_result("t1", 16'h1234, 16'h1234, 1'b0);
        @(negedge clk);
        check("t1 out_valid drop", 32'(out_valid), 32'd0);
        check("t1 idle in_ready", 32'(in_ready), 32'd1);

        // T2: back-to-back 0, 9999, 10000 with in_valid held high
        $display("[TB] T2 back-to-back 0, 9999, 10000");
        send(14'd0, 1'b1, "t2a");
        in_bin = 14'd9999;
        wait_result("t2a");
        check_result("t2a", 16'h0000, 16'h0000, 1'b0);
        send(14'd9999, 1'b1, "t2b");
        check("t2b spacing", 32'(acc_cyc - prev_acc), 32'd16);
        in_bin = 14'd10000;
        wait_result("t2b");
        check_result("t2b", 16'h9999, 16'h9999, 1'b0);
        send(14'd10000, 1'b0, "t2c");
        check("t2c spacing", 32'(acc_cyc - prev_acc), 32'd16);
        wait_result("t2c");
        check_result("t2c", 16'h9999, 16'h0000, 1'b1);
        @(negedge clk);

        // T3: largest input, wrap instance reads 6383
        $display("[TB] T3 convert 16383");
        send(14'd16383, 1'b0, "t3");
        wait_result("t3");
        check_result("t3", 16'h9999, 16'h6383, 1'b1);
        @(negedge clk);

        // T4: 4096 held under backpressure for 5 cycles
        $display("[TB] T4 backpressure on 4096");
        out_ready = 1'b0;
        send(14'd4096, 1'b0, "t4");
        wait_result("t4");
        for (int i = 0; i < 5; i++) begin
            check("t4 held out_valid", 32'(out_valid), 32'd1);
            check("t4 held digits", 32'({thousands, hundreds, tens, ones}), 32'h4096);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 release out_valid", 32'(out_valid), 32'd0);
        check("t4 release in_ready", 32'(in_ready), 32'd1);
        check("t4 digits kept", 32'({thousands, hundreds, tens, ones}), 32'h4096);

        // T5: a stray 7777 pulse during SHIFT is dropped
        $display("[TB] T5 ignore input while busy");
        send(14'd5555, 1'b0, "t5a");
        repeat (3) @(negedge clk);
        in_bin   = 14'd7777;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("t5a");
        check_result("t5a", 16'h5555, 16'h5555, 1'b0);
        repeat (4) @(negedge clk);
        check("t5 no queued out_valid", 32'(out_valid), 32'd0);
        check("t5 idle in_ready", 32'(in_ready), 32'd1);
        send(14'd7777, 1'b0, "t5b");
        wait_result("t5b");
        check_result("t5b", 16'h7777, 16'h7777, 1'b0);
        @(negedge clk);

        // T6: reset 6 cycles into converting 8191, then a fresh 42
        $display("[TB] T6 reset mid-conversion");
        send(14'd8191, 1'b0, "t6a");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6 reset in_ready", 32'(in_ready), 32'd1);
        check("t6 reset out_valid", 32'(out_valid), 32'd0);
        check_result("t6 reset", 16'h0000, 16'h0000, 1'b0);
        reset = 1'b0;
        send(14'd42, 1'b0, "t6b");
        wait_result("t6b");
        check_result("t6b", 16'h0042, 16'h0042, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
